// File: rtl/bmp_stream_packer.sv
// Captures SOF0 dimensions from a JPEG byte stream, buffers decoded RGB pixels
// and streams out a complete BMP file (header, pixels, row padding) over valid/ready.
module bmp_stream_packer #(
  parameter int COLOR_PRECISION = 8,
  parameter int BPP             = 24,
  parameter int FIFO_DEPTH      = 16,
  parameter int DIM_W           = 16,
  parameter int TOP_DOWN        = 0
) (
  input  logic                       r_sysclk,
  input  logic                       r_arst,
  input  logic                       i_jpg_byte_en,
  input  logic [7:0]                 i_jpg_byte,
  input  logic                       i_de,
  input  logic [COLOR_PRECISION-1:0] i_R,
  input  logic [COLOR_PRECISION-1:0] i_G,
  input  logic [COLOR_PRECISION-1:0] i_B,
  output logic                       o_byte_valid,
  output logic [7:0]                 o_byte,
  input  logic                       i_byte_ready,
  output logic                       o_sof_seen,
  output logic [DIM_W-1:0]           o_width,
  output logic [DIM_W-1:0]           o_height,
  output logic                       o_overflow,
  output logic                       o_frame_done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BPB = BPP / 8;
  localparam logic [1:0] LAST_SEL = 2'(BPB - 1);
  localparam logic [AW:0] FULL_CNT = FIFO_DEPTH[AW:0];
  localparam logic [DIM_W-1:0] ONE = 1;

  if (BPP != 24 && BPP != 32) begin : g_bpp_check
    $error("bmp_stream_packer: BPP must be 24 or 32");
  end

  typedef enum logic [2:0] {S_IDLE, S_HEADER, S_PIXEL, S_PAD, S_DONE} state_t;

  state_t state, state_n;
  logic [15:0] hist;
  logic parsing, sof_seen, overflow;
  logic [2:0] pidx;
  logic [7:0] hi_byte;
  logic [DIM_W-1:0] width, height;
  logic [23:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] count;
  logic fifo_full, fifo_empty, push, pop;
  logic [23:0] head;
  logic [31:0] bytes_row, stride, img_size, file_size, height_field;
  logic [1:0] pad;
  logic [5:0] hdr_idx, hdr_idx_n;
  logic [1:0] byte_sel, byte_sel_n, pad_cnt, pad_cnt_n;
  logic [DIM_W-1:0] col, col_n, row, row_n;
  logic row_end;

  function automatic logic [7:0] msb8(input logic [COLOR_PRECISION-1:0] c);
    logic [COLOR_PRECISION+7:0] w;
    w = {c, 8'h00};
    return w[COLOR_PRECISION+7 -: 8];
  endfunction

  function automatic logic [7:0] hdr_byte(input logic [5:0] i, input logic [31:0] fsz,
                                          input logic [31:0] isz, input logic [31:0] wd,
                                          input logic [31:0] ht);
    case (i)
      6'd0: return 8'h42;       6'd1: return 8'h4D;
      6'd2: return fsz[7:0];    6'd3: return fsz[15:8];
      6'd4: return fsz[23:16];  6'd5: return fsz[31:24];
      6'd10: return 8'h36;      6'd14: return 8'h28;
      6'd18: return wd[7:0];    6'd19: return wd[15:8];
      6'd20: return wd[23:16];  6'd21: return wd[31:24];
      6'd22: return ht[7:0];    6'd23: return ht[15:8];
      6'd24: return ht[23:16];  6'd25: return ht[31:24];
      6'd26: return 8'h01;      6'd28: return 8'(BPP);
      6'd34: return isz[7:0];   6'd35: return isz[15:8];
      6'd36: return isz[23:16]; 6'd37: return isz[31:24];
      6'd38, 6'd42: return 8'h13;
      6'd39, 6'd43: return 8'h0B;
      default: return 8'h00;
    endcase
  endfunction

  // SOF0 parser: bytes after FFC0 are Lh Ll P Hh Hl Wh Wl (pidx 0..6)
  always_ff @(posedge r_sysclk or posedge r_arst) begin
    if (r_arst) begin
      hist <= '0; parsing <= 1'b0; pidx <= '0; hi_byte <= '0;
      width <= '0; height <= '0; sof_seen <= 1'b0;
    end else begin
      if (state == S_DONE) sof_seen <= 1'b0;
      if (i_jpg_byte_en) begin
        hist <= {hist[7:0], i_jpg_byte};
        if (parsing) begin
          pidx <= pidx + 3'd1;
          case (pidx)
            3'd3, 3'd5: hi_byte <= i_jpg_byte;
            3'd4: height <= DIM_W'({hi_byte, i_jpg_byte});
            3'd6: begin
              width    <= DIM_W'({hi_byte, i_jpg_byte});
              parsing  <= 1'b0;
              sof_seen <= 1'b1;
            end
            default: ;
          endcase
        end else if (!sof_seen && hist == 16'hFFC0) begin
          parsing <= 1'b1;
          pidx    <= 3'd1;
        end
      end
    end
  end

  // Pixel FIFO; a push into a full FIFO is allowed when the same cycle pops
  assign fifo_full  = (count == FULL_CNT);
  assign fifo_empty = (count == '0);
  assign head = mem[rptr];
  assign pop  = o_byte_valid && i_byte_ready && (state == S_PIXEL) && (byte_sel == LAST_SEL);
  assign push = i_de && sof_seen && (!fifo_full || pop);

  always_ff @(posedge r_sysclk) begin
    if (push) mem[wptr] <= {msb8(i_R), msb8(i_G), msb8(i_B)};
  end

  always_ff @(posedge r_sysclk or posedge r_arst) begin
    if (r_arst) begin
      wptr <= '0; rptr <= '0; count <= '0; overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      if (i_de && sof_seen && !push) overflow <= 1'b1;
    end
  end

  assign bytes_row    = 32'(width) * 32'(BPB);
  assign pad          = 2'(32'd0 - bytes_row);
  assign stride       = bytes_row + 32'(pad);
  assign img_size     = stride * 32'(height);
  assign file_size    = img_size + 32'd54;
  assign height_field = (TOP_DOWN != 0) ? 32'd0 - 32'(height) : 32'(height);

  // Output FSM
  always_ff @(posedge r_sysclk or posedge r_arst) begin
    if (r_arst) begin
      state <= S_IDLE; hdr_idx <= '0; byte_sel <= '0;
      pad_cnt <= '0; col <= '0; row <= '0;
    end else begin
      state <= state_n; hdr_idx <= hdr_idx_n; byte_sel <= byte_sel_n;
      pad_cnt <= pad_cnt_n; col <= col_n; row <= row_n;
    end
  end

  always_comb begin
    state_n = state; hdr_idx_n = hdr_idx; byte_sel_n = byte_sel;
    pad_cnt_n = pad_cnt; col_n = col; row_n = row;
    row_end = 1'b0;
    o_byte_valid = 1'b0; o_byte = 8'h00; o_frame_done = 1'b0;
    case (state)
      S_IDLE: begin
        hdr_idx_n = '0; byte_sel_n = '0; pad_cnt_n = '0; col_n = '0; row_n = '0;
        if (sof_seen) state_n = S_HEADER;
      end
      S_HEADER: begin
        o_byte_valid = 1'b1;
        o_byte = hdr_byte(hdr_idx, file_size, img_size, 32'(width), height_field);
        if (i_byte_ready) begin
          hdr_idx_n = hdr_idx + 6'd1;
          if (hdr_idx == 6'd53)
            state_n = (width == '0 || height == '0) ? S_DONE : S_PIXEL;
        end
      end
      S_PIXEL: begin
        o_byte_valid = !fifo_empty;
        case (byte_sel)
          2'd0:    o_byte = head[7:0];
          2'd1:    o_byte = head[15:8];
          2'd2:    o_byte = head[23:16];
          default: o_byte = 8'hFF;
        endcase
        if (o_byte_valid && i_byte_ready) begin
          if (byte_sel == LAST_SEL) begin
            byte_sel_n = '0;
            if (col == width - ONE) begin
              if (pad != 2'd0) begin
                state_n = S_PAD;
                col_n   = '0;
              end else row_end = 1'b1;
            end else col_n = col + ONE;
          end else byte_sel_n = byte_sel + 2'd1;
        end
      end
      S_PAD: begin
        o_byte_valid = 1'b1;
        if (i_byte_ready) begin
          if (pad_cnt == pad - 2'd1) row_end = 1'b1;
          else pad_cnt_n = pad_cnt + 2'd1;
        end
      end
      S_DONE: begin
        o_frame_done = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    if (row_end) begin
      col_n = '0; pad_cnt_n = '0;
      if (row == height - ONE) state_n = S_DONE;
      else begin
        row_n   = row + ONE;
        state_n = S_PIXEL;
      end
    end
  end

  assign o_sof_seen = sof_seen;
  assign o_width    = width;
  assign o_height   = height;
  assign o_overflow = overflow;

endmodule
